// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM encodings, opcode constants and widths for the SPI slave.
package spi_pkg;
  localparam int ADDR_SIZE_DEF = 8;
  localparam int CMD_W = ADDR_SIZE_DEF + 2;
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} spi_state_t;
  typedef enum logic [1:0] {PH_RX, PH_WAIT, PH_TX} rd_phase_t;
endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: shift register with parallel load and bit counter; serial in at the LSB, serial out from the MSB.
module spi_shift_reg #(
  parameter int W = 10,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic          shift,
  input  logic          sin,
  input  logic [W-1:0]  pdata,
  output logic [W-1:0]  q,
  output logic [CW-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      q <= pdata;
      cnt <= '0;
    end else if (shift) begin
      q <= {q[W-2:0], sin};
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI front end for the single-port RAM; MOSI frames become rx_data words and RAM read bytes return on MISO.
// Define SPI_CMD_CHECK_EN to add opcode checking per frame type with a cmd_err strobe.
module spi_slave
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
`ifdef SPI_CMD_CHECK_EN
  ,
  output logic                 cmd_err
`endif
);
  localparam int W = ADDR_SIZE + 2;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] RX_LAST = CW'(W - 1);
  localparam logic [CW-1:0] TX_DONE = CW'(ADDR_SIZE);
  spi_state_t state, state_n;
  rd_phase_t phase, phase_n;
  logic [W-1:0] sr_q, word, rx_data_n;
  logic [CW-1:0] cnt;
  logic clr, load, shift, done, ok;
  logic rx_valid_n, miso_n, rd_addr_seen, rd_addr_seen_n;
`ifdef SPI_CMD_CHECK_EN
  logic cmd_err_n;
`endif
  spi_shift_reg #(.W(W), .CW(CW)) u_sr (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .load(load),
    .shift(shift),
    .sin(MOSI),
    .pdata({tx_data, 2'b00}),
    .q(sr_q),
    .cnt(cnt)
  );
  always_comb begin
    state_n = state;
    phase_n = phase;
    rx_data_n = rx_data;
    rx_valid_n = 1'b0;
    miso_n = 1'b0;
    rd_addr_seen_n = rd_addr_seen;
    clr = 1'b0;
    load = 1'b0;
    shift = 1'b0;
    done = 1'b0;
    word = {sr_q[W-2:0], MOSI};
`ifdef SPI_CMD_CHECK_EN
    cmd_err_n = 1'b0;
    ok = state == WRITE ? (word[W-1:W-2] == OP_WR_ADDR || word[W-1:W-2] == OP_WR_DATA) :
         state == READ_ADD ? word[W-1:W-2] == OP_RD_ADDR : word[W-1:W-2] == OP_RD_DATA;
`else
    ok = 1'b1;
`endif
    if (state != IDLE && SS_n) begin
      state_n = IDLE;
      clr = 1'b1;
    end else begin
      case (state)
        IDLE: state_n = SS_n ? IDLE : CHK_CMD;
        CHK_CMD: begin
          clr = 1'b1;
          phase_n = PH_RX;
          state_n = !MOSI ? WRITE : rd_addr_seen ? READ_DATA : READ_ADD;
        end
        WRITE, READ_ADD: begin
          shift = 1'b1;
          done = cnt == RX_LAST;
        end
        default: begin
          case (phase)
            PH_RX: begin
              shift = 1'b1;
              done = cnt == RX_LAST;
            end
            PH_WAIT: begin
              load = tx_valid;
              phase_n = tx_valid ? PH_TX : PH_WAIT;
            end
            default: begin
              // MISO is registered, so bit 7 appears one edge after the load
              if (cnt == TX_DONE) begin
                state_n = IDLE;
                rd_addr_seen_n = 1'b0;
                clr = 1'b1;
              end else begin
                miso_n = sr_q[W-1];
                shift = 1'b1;
              end
            end
          endcase
        end
      endcase
    end
    if (done) begin
      state_n = (state == READ_DATA && ok) ? READ_DATA : IDLE;
      phase_n = PH_WAIT;
      clr = 1'b1;
      if (ok) begin
        rx_data_n = word;
        rx_valid_n = 1'b1;
        rd_addr_seen_n = rd_addr_seen | (state == READ_ADD);
      end
`ifdef SPI_CMD_CHECK_EN
      cmd_err_n = !ok;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= PH_RX;
      rx_data <= '0;
      rx_valid <= 1'b0;
      MISO <= 1'b0;
      rd_addr_seen <= 1'b0;
`ifdef SPI_CMD_CHECK_EN
      cmd_err <= 1'b0;
`endif
    end else begin
      state <= state_n;
      phase <= phase_n;
      rx_data <= rx_data_n;
      rx_valid <= rx_valid_n;
      MISO <= miso_n;
      rd_addr_seen <= rd_addr_seen_n;
`ifdef SPI_CMD_CHECK_EN
      cmd_err <= cmd_err_n;
`endif
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed self-checking bench for spi_slave (write, read address/data, aborts, async reset, opcode check).
module tb_spi_slave;
  import spi_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic SS_n = 1'b1;
  logic MOSI = 1'b0;
  logic tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic MISO, rx_valid;
  logic [9:0] rx_data;
  logic [7:0] exp_byte;
  logic prev_rv = 1'b0;
  int tests = 0;
  int fails = 0;
  int pulses = 0;
  int doubles = 0;
  int p0;
`ifdef SPI_CMD_CHECK_EN
  logic cmd_err;
`endif
  spi_slave #(.ADDR_SIZE(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .SS_n(SS_n),
    .MOSI(MOSI),
    .MISO(MISO),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_data(tx_data),
    .tx_valid(tx_valid)
`ifdef SPI_CMD_CHECK_EN
    ,
    .cmd_err(cmd_err)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (rx_valid) pulses++;
    if (rx_valid && prev_rv) doubles++;
    prev_rv = rx_valid;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic frame(input logic cmd, input logic [9:0] w);
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = 1'b0;
    @(negedge clk);
    MOSI = cmd;
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      MOSI = w[i];
    end
    @(negedge clk);
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_miso", 32'(MISO), 32'h0);
    chk("rst_seen", 32'(dut.rd_addr_seen), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // write address
    frame(1'b0, 10'h005);
    chk("wa_valid", 32'(rx_valid), 32'h1);
    chk("wa_data", 32'(rx_data), 32'h005);
    chk("wa_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    SS_n = 1'b1;
    chk("wa_pulse_len", 32'(rx_valid), 32'h0);
    chk("wa_pulses", 32'(pulses), 32'h1);
    // write data, with stray tx_valid that must be ignored
    tx_valid = 1'b1;
    tx_data = 8'hFF;
    frame(1'b0, 10'h1AA);
    chk("wd_valid", 32'(rx_valid), 32'h1);
    chk("wd_data", 32'(rx_data), 32'h1AA);
    chk("wd_miso_idle", 32'(MISO), 32'h0);
    @(negedge clk);
    SS_n = 1'b1;
    tx_valid = 1'b0;
    chk("wd_pulse_len", 32'(rx_valid), 32'h0);
    chk("wd_hold", 32'(rx_data), 32'h1AA);
    // read address
    frame(1'b1, 10'h205);
    chk("ra_valid", 32'(rx_valid), 32'h1);
    chk("ra_data", 32'(rx_data), 32'h205);
    chk("ra_seen", 32'(dut.rd_addr_seen), 32'h1);
    @(negedge clk);
    SS_n = 1'b1;
    // read data: RAM answers during the rx_valid cycle
    frame(1'b1, 10'h3C5);
    chk("rd_valid", 32'(rx_valid), 32'h1);
    chk("rd_data", 32'(rx_data), 32'h3C5);
    chk("rd_opcode", 32'(rx_data[9:8]), 32'h3);
    tx_data = 8'hAA;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data = 8'h55;
    chk("rd_miso_pre", 32'(MISO), 32'h0);
    chk("rd_pulse_len", 32'(rx_valid), 32'h0);
    exp_byte = 8'hAA;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      chk($sformatf("rd_miso_bit%0d", i), 32'(MISO), 32'(exp_byte[i]));
    end
    @(negedge clk);
    chk("rd_miso_end", 32'(MISO), 32'h0);
    chk("rd_seen_clr", 32'(dut.rd_addr_seen), 32'h0);
    chk("rd_state_end", 32'(dut.state), 32'(IDLE));
    SS_n = 1'b1;
    // abort a write frame after 5 bits
    p0 = pulses;
    @(negedge clk);
    SS_n = 1'b0;
    @(negedge clk);
    MOSI = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      MOSI = i[0];
    end
    @(negedge clk);
    SS_n = 1'b1;
    @(negedge clk);
    chk("ab_state", 32'(dut.state), 32'(IDLE));
    chk("ab_cnt", 32'(dut.cnt), 32'h0);
    chk("ab_no_pulse", 32'(pulses), 32'(p0));
    frame(1'b0, 10'h0F3);
    chk("ab_next_valid", 32'(rx_valid), 32'h1);
    chk("ab_next_data", 32'(rx_data), 32'h0F3);
    @(negedge clk);
    SS_n = 1'b1;
    // abort while waiting for tx_valid keeps rd_addr_seen
    frame(1'b1, 10'h205);
    @(negedge clk);
    SS_n = 1'b1;
    frame(1'b1, 10'h311);
    chk("aw_valid", 32'(rx_valid), 32'h1);
    SS_n = 1'b1;
    @(negedge clk);
    chk("aw_state", 32'(dut.state), 32'(IDLE));
    chk("aw_seen", 32'(dut.rd_addr_seen), 32'h1);
    chk("aw_miso", 32'(MISO), 32'h0);
    // async reset in the middle of MISO shift-out
    frame(1'b1, 10'h3FF);
    chk("rs_valid", 32'(rx_valid), 32'h1);
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    chk("rs_miso_b7", 32'(MISO), 32'h1);
    @(negedge clk);
    chk("rs_miso_b6", 32'(MISO), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_miso", 32'(MISO), 32'h0);
    chk("rs_rx_valid", 32'(rx_valid), 32'h0);
    chk("rs_rx_data", 32'(rx_data), 32'h0);
    chk("rs_seen", 32'(dut.rd_addr_seen), 32'h0);
    chk("rs_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    SS_n = 1'b1;
    // write frame carrying opcode 11
    p0 = pulses;
    frame(1'b0, 10'h3AB);
`ifdef SPI_CMD_CHECK_EN
    chk("ce_no_valid", 32'(rx_valid), 32'h0);
    chk("ce_err", 32'(cmd_err), 32'h1);
    chk("ce_data_hold", 32'(rx_data), 32'h0);
    @(negedge clk);
    chk("ce_err_len", 32'(cmd_err), 32'h0);
    chk("ce_no_pulse", 32'(pulses), 32'(p0));
`else
    chk("op11_valid", 32'(rx_valid), 32'h1);
    chk("op11_opcode", 32'(rx_data[9:8]), 32'h3);
    chk("op11_data", 32'(rx_data), 32'h3AB);
    @(negedge clk);
`endif
    SS_n = 1'b1;
    @(negedge clk);
    chk("no_double_pulse", 32'(doubles), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
